// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns HI/LO. It computes one radix-2 step per cycle.
// Latency is 1 issue cycle plus WIDTH busy cycles; stall_o holds the pipeline for that whole span.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic [1:0]       hilo_we_i,
    input  logic [WIDTH-1:0] hilo_wdata_i,
    output logic             stall_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   acc_q, acc_d;      // product upper half / partial remainder
    logic [WIDTH-1:0] wrk_q, wrk_d;      // multiplier / dividend-quotient shift register
    logic [WIDTH-1:0] opb_q, opb_d;      // multiplicand / divisor magnitude
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic             issue, last;
    logic             sgn, a_neg, b_neg;
    logic [WIDTH:0]   mul_sum, step_acc, rem_sh;
    logic [WIDTH+1:0] diff;
    logic [WIDTH-1:0] step_wrk, quo, rem;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign issue = (state_q == S_IDLE) && start_i && !flush_i;
    assign last  = (state_q == S_BUSY) && (count_q == CW'(WIDTH - 1));
    assign sgn   = !op_i[0];
    assign a_neg = sgn && a_i[WIDTH-1];
    assign b_neg = sgn && b_i[WIDTH-1];

    // One shift-add or restoring-subtract step on the current working registers
    always_comb begin
        mul_sum  = wrk_q[0] ? (acc_q + {1'b0, opb_q}) : acc_q;
        rem_sh   = {acc_q[WIDTH-1:0], wrk_q[WIDTH-1]};
        diff     = {1'b0, rem_sh} - {2'b00, opb_q};
        step_acc = {1'b0, mul_sum[WIDTH:1]};
        step_wrk = {mul_sum[0], wrk_q[WIDTH-1:1]};
        if (is_div_q) begin
            step_acc = diff[WIDTH+1] ? rem_sh : diff[WIDTH:0];
            step_wrk = {wrk_q[WIDTH-2:0], !diff[WIDTH+1]};
        end
    end

    // Sign fix-up; divide by zero forces an all-ones quotient while the remainder is the dividend
    always_comb begin
        prod   = {step_acc[WIDTH-1:0], step_wrk};
        prod   = neg_res_q ? -prod : prod;
        quo    = neg_res_q ? -step_wrk : step_wrk;
        rem    = neg_rem_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
        res_hi = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo = is_div_q ? (div0_q ? '1 : quo) : prod[WIDTH-1:0];
    end

    always_comb begin
        count_d   = count_q;
        acc_d     = acc_q;
        wrk_d     = wrk_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (issue) begin
            count_d   = '0;
            acc_d     = '0;
            is_div_d  = op_i[1];
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            div0_d    = (b_i == '0);
            wrk_d     = op_i[1] ? (a_neg ? -a_i : a_i) : (b_neg ? -b_i : b_i);
            opb_d     = op_i[1] ? (b_neg ? -b_i : b_i) : (a_neg ? -a_i : a_i);
        end else if (state_q == S_BUSY) begin
            count_d = count_q + CW'(1);
            acc_d   = step_acc;
            wrk_d   = step_wrk;
        end
        if (state_q == S_IDLE && !start_i) begin
            if (hilo_we_i[1]) hi_d = hilo_wdata_i;
            if (hilo_we_i[0]) lo_d = hilo_wdata_i;
        end
        if (last && !flush_i) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue) state_d = S_BUSY;
            S_BUSY:  if (flush_i) state_d = S_IDLE;
                     else if (last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            S_IDLE:  stall_o = start_i && !flush_i;
            S_BUSY:  stall_o = !flush_i;
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            acc_q     <= '0;
            wrk_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            count_q   <= count_d;
            acc_q     <= acc_d;
            wrk_q     <= wrk_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO and stall length; monitor pops on each stall release.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        flush_i;
    logic [1:0]  hilo_we_i;
    logic [31:0] hilo_wdata_i;
    logic        stall_o;
    logic [31:0] hi_o, lo_o;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .op_i         (op_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .flush_i      (flush_i),
        .hilo_we_i    (hilo_we_i),
        .hilo_wdata_i (hilo_wdata_i),
        .stall_o      (stall_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;   // expected stall length, 0 = not checked
        string       name;
    } exp_t;

    exp_t scb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   run_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Plain arithmetic reference: 64-bit products, truncating division
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sbv, q, r;
        longint unsigned ua, ub, p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        if (op[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
        case (op)
            2'd0: begin p = longint'(sa * sbv); return p; end
            2'd1: begin p = ua * ub; return p; end
            2'd2: begin q = sa / sbv; r = sa % sbv; return {r[31:0], q[31:0]}; end
            default: begin p = ua / ub; q = longint'(ua % ub); return {q[31:0], p[31:0]}; end
        endcase
    endfunction

    // Monitor: a falling stall_o marks the end of an op (DONE, flush or reset abort)
    always @(negedge clk) begin
        if (stall_o === 1'b1) begin
            run_len++;
        end else if (run_len > 0) begin
            if (scb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got stall run %0d expected no op in flight", run_len);
            end else begin
                mon_e = scb.pop_front();
                if (mon_e.len != 0) check({mon_e.name, " stall_len"}, 32'(run_len), 32'(mon_e.len));
                check({mon_e.name, " hi"}, hi_o, mon_e.hi);
                check({mon_e.name, " lo"}, lo_o, mon_e.lo);
            end
            run_len = 0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the DONE cycle with start_i low
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble);
        exp_t e;
        logic [63:0] r;
        int n;
        r = ref_model(op, a, b);
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.len = 33;
        e.name = $sformatf("op%0d %h,%h", op, a, b);
        scb.push_back(e);
        start_i = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall_o) break;
            n++;
            if (scramble && n == 5) begin
                a_i = $urandom;
                b_i = $urandom;
                hilo_we_i = 2'b11;
                hilo_wdata_i = $urandom;
            end
            if (scramble && n == 7) hilo_we_i = 2'b00;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL %s timeout: got stall beyond %0d cycles expected 33", e.name, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        hilo_we_i = 2'b00;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        start_i = 1'b0;
        op_i = 2'd0;
        a_i = '0;
        b_i = '0;
        flush_i = 1'b0;
        hilo_we_i = 2'b00;
        hilo_wdata_i = '0;

        @(posedge clk);
        @(negedge clk);
        check("reset stall", {31'd0, stall_o}, 32'd0);
        check("reset hi", hi_o, 32'd0);
        check("reset lo", lo_o, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases, back-to-back with no idle gap
        do_op(2'd0, 32'd7, 32'd6, 1'b0);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(2'd3, 32'd100, 32'd0, 1'b0);
        do_op(2'd2, 32'hFFFF_FFFB, 32'd0, 1'b0);
        do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);

        // MTHI/MTLO preload, then a DIVU flushed on its tenth busy cycle
        hilo_we_i = 2'b10;
        hilo_wdata_i = 32'h11;
        @(posedge clk);
        #1 hilo_we_i = 2'b01;
        hilo_wdata_i = 32'h22;
        @(negedge clk);
        check("mthi", hi_o, 32'h11);
        @(posedge clk);
        #1 hilo_we_i = 2'b00;
        @(negedge clk);
        check("mtlo", lo_o, 32'h22);
        @(posedge clk);
        #1;
        e.hi = 32'h11;
        e.lo = 32'h22;
        e.len = 10;
        e.name = "divu flush";
        scb.push_back(e);
        start_i = 1'b1;
        op_i = 2'd3;
        a_i = 32'd9;
        b_i = 32'd3;
        repeat (10) @(posedge clk);
        #1 flush_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        check("flush stall same cycle", {31'd0, stall_o}, 32'd0);
        @(posedge clk);
        #1 flush_i = 1'b0;
        @(negedge clk);
        check("after flush stall", {31'd0, stall_o}, 32'd0);
        check("after flush hi", hi_o, 32'h11);
        check("after flush lo", lo_o, 32'h22);

        // Synchronous reset in the middle of a multiply
        @(posedge clk);
        #1;
        e.hi = 32'd0;
        e.lo = 32'd0;
        e.len = 0;
        e.name = "reset abort";
        scb.push_back(e);
        start_i = 1'b1;
        op_i = 2'd0;
        a_i = 32'd5;
        b_i = 32'd5;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post reset stall", {31'd0, stall_o}, 32'd0);
        check("post reset hi", hi_o, 32'd0);
        check("post reset lo", lo_o, 32'd0);
        @(posedge clk);
        #1;
        do_op(2'd0, 32'd3, 32'd3, 1'b0);

        // Randomized ops with random gaps, some with operand and MTxx noise mid-flight
        for (int i = 0; i < 25; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            do_op(2'($urandom_range(0, 3)), pick(), pick(), ($urandom_range(0, 2) == 0));
        end

        repeat (3) @(negedge clk);
        total++;
        if (scb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", scb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
